// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I control FSM and its datapath.
// master = control FSM, slave = datapath side.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       mem_req;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_mode;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, adr_src, mem_write, mem_req, ir_write, result_src,
           alu_src_a, alu_src_b, alu_mode, reg_write, illegal, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, adr_src, mem_write, mem_req, ir_write, result_src,
           alu_src_a, alu_src_b, alu_mode, reg_write, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/
// writeback sequencing with a mem_ready stall handshake.
module multicycle_control_fsm (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_write, w_adr_src, w_mem_write, w_mem_req, w_ir_write;
  logic       w_reg_write, w_illegal;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_mode;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_req    = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_mode   = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        w_next       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        unique case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        w_next    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_mode  = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_mode  = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_mode  = 2'b01;
        w_pc_write  = bus.zero;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks the outputs combinationally so strobes drop in the cycle reset rises.
  always_comb begin
    bus.pc_write   = w_pc_write  & ~reset;
    bus.adr_src    = w_adr_src   & ~reset;
    bus.mem_write  = w_mem_write & ~reset;
    bus.mem_req    = w_mem_req   & ~reset;
    bus.ir_write   = w_ir_write  & ~reset;
    bus.reg_write  = w_reg_write & ~reset;
    bus.illegal    = w_illegal   & ~reset;
    bus.result_src = reset ? 2'b00 : w_result_src;
    bus.alu_src_a  = reset ? 2'b00 : w_alu_src_a;
    bus.alu_src_b  = reset ? 2'b00 : w_alu_src_b;
    bus.alu_mode   = reset ? 2'b00 : w_alu_mode;
    bus.state_dbg  = reset ? 4'd0  : r_state;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm: an instruction-level
// model expands each instruction into its expected per-cycle state/control trace.
module tb_multicycle_control_fsm;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                 MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   n_ir, n_pc, n_mw, n_rw, n_ill, n_cyc;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL;
  endfunction

  // {pc_write, adr_src, mem_write, mem_req, ir_write, result_src, alu_src_a, alu_src_b, alu_mode, reg_write, illegal}
  function automatic logic [14:0] exp_word(input int st, input logic rdy, input logic z,
                                           input logic [6:0] op);
    logic pcw = 0, adr = 0, mw = 0, req = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, a = 0, b = 0, mode = 0;
    case (st)
      FETCH:    begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      DECODE:   begin a = 2'b01; b = 2'b01; ill = !is_legal(op); end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  begin req = 1; adr = 1; end
      MEMWB:    begin res = 2'b01; rw = 1; end
      MEMWRITE: begin req = 1; adr = 1; mw = 1; end
      EXECR:    begin a = 2'b10; b = 2'b00; mode = 2'b10; end
      EXECI:    begin a = 2'b10; b = 2'b01; mode = 2'b10; end
      ALUWB:    begin rw = 1; end
      BEQ:      begin a = 2'b10; mode = 2'b01; pcw = z; end
      JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      default:  ;
    endcase
    return {pcw, adr, mw, req, irw, res, a, b, mode, rw, ill};
  endfunction

  function automatic logic [14:0] obs_word();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.mem_req, bus.ir_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_mode,
            bus.reg_write, bus.illegal};
  endfunction

  task automatic clear_counts();
    n_ir = 0; n_pc = 0; n_mw = 0; n_rw = 0; n_ill = 0; n_cyc = 0;
  endtask

  // One clock: drive inputs, check state and controls at the falling edge, advance.
  task automatic step(input logic [6:0] op, input logic z, input logic rdy, input int st);
    logic [14:0] exp;
    logic [3:0]  st4;
    bus.opcode = op; bus.zero = z; bus.mem_ready = rdy;
    @(negedge clk);
    exp = exp_word(st, rdy, z, op);
    st4 = 4'(st);
    total++;
    if (bus.state_dbg !== st4)
      $display("FAIL state op=%b: got %0d expected %0d", op, bus.state_dbg, st4);
    else passed++;
    total++;
    if (obs_word() !== exp)
      $display("FAIL controls state=%0d op=%b rdy=%b z=%b: got %b expected %b",
               st, op, rdy, z, obs_word(), exp);
    else passed++;
    n_ir += int'(bus.ir_write); n_pc += int'(bus.pc_write);
    n_mw += int'(bus.mem_write); n_rw += int'(bus.reg_write);
    n_ill += int'(bus.illegal); n_cyc++;
    @(posedge clk); #1;
  endtask

  // Expand one instruction into its state trace from the instruction class rules.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    int   st_q[$];
    logic rdy_q[$];
    for (int i = 0; i < fw; i++) begin st_q.push_back(FETCH); rdy_q.push_back(1'b0); end
    st_q.push_back(FETCH);  rdy_q.push_back(1'b1);
    st_q.push_back(DECODE); rdy_q.push_back(1'($urandom));
    if (op == LW || op == SW) begin
      int mst = (op == LW) ? MEMREAD : MEMWRITE;
      st_q.push_back(MEMADR); rdy_q.push_back(1'($urandom));
      for (int i = 0; i < mw; i++) begin st_q.push_back(mst); rdy_q.push_back(1'b0); end
      st_q.push_back(mst); rdy_q.push_back(1'b1);
      if (op == LW) begin st_q.push_back(MEMWB); rdy_q.push_back(1'($urandom)); end
    end else if (op == RT || op == IT) begin
      st_q.push_back(op == RT ? EXECR : EXECI); rdy_q.push_back(1'($urandom));
      st_q.push_back(ALUWB); rdy_q.push_back(1'($urandom));
    end else if (op == BQ) begin
      st_q.push_back(BEQ); rdy_q.push_back(1'($urandom));
    end else if (op == JL) begin
      st_q.push_back(JAL); rdy_q.push_back(1'($urandom));
      st_q.push_back(ALUWB); rdy_q.push_back(1'($urandom));
    end
    foreach (st_q[i]) step(op, z, rdy_q[i], st_q[i]);
  endtask

  task automatic reset_cycle();
    bus.opcode = 7'($urandom); bus.zero = 1'($urandom); bus.mem_ready = 1'($urandom);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (obs_word() !== 15'd0 || bus.state_dbg !== 4'd0)
      $display("FAIL reset_outputs: got %b state %0d expected all zero", obs_word(), bus.state_dbg);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) reset_cycle();
    reset = 1'b0;
    clear_counts();
    run_instr(RT, 0, 0, 1'b0);
    step(RT, 1'b0, 1'b0, FETCH);
  endtask

  task automatic test_lw();
    clear_counts();
    run_instr(LW, 2, 3, 1'b0);
    total++;
    if (n_cyc != 10 || n_ir != 1 || n_pc != 1)
      $display("FAIL lw_counts: cycles %0d ir %0d pc %0d expected 10 1 1", n_cyc, n_ir, n_pc);
    else passed++;
  endtask

  task automatic test_sw();
    clear_counts();
    run_instr(SW, 0, 1, 1'b1);
    total++;
    if (n_mw != 2 || n_rw != 0)
      $display("FAIL sw_strobes: mem_write %0d reg_write %0d expected 2 0", n_mw, n_rw);
    else passed++;
  endtask

  task automatic test_beq();
    for (int z = 0; z < 2; z++) begin
      clear_counts();
      run_instr(BQ, 0, 0, 1'(z));
      total++;
      if (n_cyc != 3 || n_pc != 1 + z)
        $display("FAIL beq z=%0d: cycles %0d pc_write %0d expected 3 %0d", z, n_cyc, n_pc, 1 + z);
      else passed++;
    end
  endtask

  task automatic test_jal();
    run_instr(JL, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    clear_counts();
    run_instr(7'b1111111, 0, 0, 1'b0);
    step(7'b1111111, 1'b0, 1'b0, FETCH);
    total++;
    if (n_ill != 1 || n_rw != 0 || n_mw != 0)
      $display("FAIL illegal: illegal %0d reg_write %0d mem_write %0d expected 1 0 0",
               n_ill, n_rw, n_mw);
    else passed++;
  endtask

  task automatic test_reset_mid_memwrite();
    step(SW, 1'b0, 1'b1, FETCH);
    step(SW, 1'b0, 1'b0, DECODE);
    step(SW, 1'b0, 1'b0, MEMADR);
    step(SW, 1'b0, 1'b0, MEMWRITE);
    step(SW, 1'b0, 1'b0, MEMWRITE);
    reset_cycle();
    reset = 1'b0;
    step(SW, 1'b0, 1'b0, FETCH);
    step(SW, 1'b0, 1'b1, FETCH);
    step(SW, 1'b0, 1'b0, DECODE);
    step(SW, 1'b0, 1'b1, MEMADR);
    step(SW, 1'b0, 1'b1, MEMWRITE);
  endtask

  task automatic test_random();
    logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 6) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
      end else op = ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_memwrite();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on a memory ready handshake. It drives the datapath multiplexers and write enables, and supplies the ALU decoder with its mode select, which chooses a forced operation or a funct3-decoded operation.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register
- zero  in  1  ALU zero flag, valid in the BEQ state
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write strobe
- mem_req  out  1  memory access request
- ir_write  out  1  instruction register and OldPC load enable
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = const 4
- alu_mode  out  2  to ALU decoder: 00 = force ADD, 01 = force XOR, 10 = decode funct3
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
- state_dbg  out  4  current state encoding, for debug only

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10
  - Encodings 11–15 are unused and must go to FETCH on the next clock.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_mode=00, result_src=10.
  - While mem_ready=0, hold FETCH with ir_write=0 and pc_write=0.
  - When mem_ready=1, assert ir_write=1 and pc_write=1 (PC <= PC+4), then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_mode=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 (beq) -> BEQ
  - 1101111 (jal) -> JAL
  - any other opcode -> FETCH, with illegal=1 for this cycle
- MEMADR: alu_src_a=10, alu_src_b=01, alu_mode=00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1. Hold until mem_ready=1, then go to FETCH. mem_write stays high for every cycle of the hold.
- EXECR: alu_src_a=10, alu_src_b=00, alu_mode=10, then go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_mode=10, then go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_mode=01 (XOR; equal operands give zero=1), result_src=00.
  - pc_write = zero (PC <= ALUOut, the target).
  - Then go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_mode=00 (OldPC+4 into ALUOut), result_src=00, pc_write=1 (PC <= target).
  - Then go to ALUWB.
- Default values: every output not listed for a state is 0. Mux selects default to 00 or 0.

## Timing
- The state register updates on the rising edge of clk.
- All outputs are combinational from the state register, except:
  - the mem_ready terms in FETCH (ir_write, pc_write)
  - the zero term in BEQ (pc_write)
- Reset:
  - While reset=1, all enables and strobes are forced to 0: pc_write, ir_write, mem_write, mem_req, reg_write, illegal.
  - Mux selects read 00 or 0; state_dbg reads 0.
  - The first clock with reset=0 is FETCH.
- Reset mid-operation: reset=1 at any state (including a stalled MEMWRITE) returns to FETCH on the next edge. mem_write drops in the same cycle reset rises.
- Cycle counts with mem_ready tied to 1 (each memory state adds one cycle per wait cycle):
  - lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in every other state.
- At most one memory access is outstanding at a time. mem_req never deasserts before mem_ready=1, except on reset.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 and opcode=0110011:
  - During reset: all strobes 0, state_dbg=0.
  - After release: states FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in ALUWB; alu_mode=10 only in EXECR.
- lw (0000011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - Total 10 cycles.
  - ir_write and pc_write assert exactly once, on the FETCH cycle with mem_ready=1.
  - adr_src=1 throughout MEMREAD.
- sw (0100011) with 1 wait cycle: mem_write=1 for exactly 2 cycles; reg_write never asserts; returns to FETCH.
- beq (1100011):
  - zero=1 gives pc_write=1 in BEQ, alu_mode=01.
  - zero=0 gives pc_write=0.
  - Both cases take 3 cycles.
- jal (1101111): sequence FETCH, DECODE, JAL (pc_write=1, alu_src_a=01, alu_src_b=10), ALUWB (reg_write=1), FETCH.
- Illegal opcode 1111111: illegal=1 for one DECODE cycle, then FETCH; no reg_write or mem_write. Separately, reset asserted during a stalled MEMWRITE: mem_write goes to 0 immediately and the state is FETCH after reset is released.
